// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encoding and default widths.
package mem_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 32;
  localparam int DEPTH_DEF   = 64;
  localparam int WORD_OFFSET = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder_array.sv
// Word-addressed storage: synchronous write port, combinational read port.
module mem_array #(
  parameter int    DATA_W      = 32,
  parameter int    DEPTH_WORDS = 64,
  parameter string INIT_FILE   = ""
) (
  input  logic                           clk,
  input  logic                           we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr_i,
  input  logic [DATA_W-1:0]              wdata_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr_i,
  output logic [DATA_W-1:0]              rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures a request, stalls WAIT_CYCLES, then pulses ready with err/rdata.
module mem_responder
  import mem_pkg::*;
#(
  parameter int    DATA_W      = DATA_W_DEF,
  parameter int    ADDR_W      = ADDR_W_DEF,
  parameter int    DEPTH_WORDS = DEPTH_DEF,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              bad_q, bad_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mem_rdata;
  logic              req_bad;
  logic              mem_we;

  assign req_bad = (addr[WORD_OFFSET-1:0] != '0) ||
                   (addr[ADDR_W-1:WORD_OFFSET+IDX_W] != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    bad_d   = bad_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          bad_d   = req_bad;
          idx_d   = addr[WORD_OFFSET +: IDX_W];
          wdata_d = wdata;
          cnt_d   = '0;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            if (!we && !req_bad) rdata_d = mem_rdata;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
          state_d = RESP;
          if (!we_q && !bad_q) rdata_d = mem_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      bad_q   <= bad_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // The store commits on the edge that ends RESP, so a reset before then drops it.
  assign mem_we = (state_q == RESP) && we_q && !bad_q;

  mem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_WORDS(DEPTH_WORDS),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(idx_q),
    .wdata_i(wdata_q),
    .raddr_i(idx_d),
    .rdata_o(mem_rdata)
  );

  assign ready = (state_q == RESP);
  assign err   = (state_q == RESP) && bad_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with two wait states, one with none, shared clock and reset.
module tb_mem_responder;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req   = '0;
  logic [1:0]  we    = '0;
  logic [1:0]  ready;
  logic [1:0]  err;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int waitOf [2] = '{2, 0};

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        expErr;
  } vec_t;

  exp_t        sb [$];
  logic [31:0] modelMem [2][64];
  logic [31:0] modelRd  [2];
  vec_t        vecs [15];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  mem_responder #(.WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .err(err[0])
  );

  mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .err(err[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Model updates at drive time; transactions never overlap, so order is preserved.
  task automatic pushExpect(input int d, input logic w, input logic [31:0] a,
                            input logic [31:0] dat, input logic expErr);
    exp_t e;
    e.err = expErr;
    if (!expErr && !w) modelRd[d] = modelMem[d][a[7:2]];
    if (!expErr && w)  modelMem[d][a[7:2]] = dat;
    e.rdata = modelRd[d];
    sb.push_back(e);
  endtask

  task automatic popCheck(input int d, input string name);
    exp_t e;
    e = sb.pop_front();
    checkOutput({name, " err"},   {31'd0, err[d]}, {31'd0, e.err});
    checkOutput({name, " rdata"}, rdata[d], e.rdata);
  endtask

  // scramble: after capture, perturb we/addr/wdata while req stays high.
  task automatic applyStimulus(input int d, input logic w, input logic [31:0] a,
                               input logic [31:0] dat, input logic expErr,
                               input bit scramble, input string name, output int readyCycle);
    int lat;
    bit seen;
    pushExpect(d, w, a, dat, expErr);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = dat;
    lat = 0; seen = 0; readyCycle = -1;
    while (!seen && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (scramble && lat == 1) begin
        we[d] = ~w; addr[d] = a ^ 32'h4; wdata[d] = ~dat;
      end
      if (ready[d]) seen = 1;
    end
    req[d] = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("[TB] FAIL %s timeout: no ready within %0d cycles", name, lat);
      void'(sb.pop_front());
    end else begin
      readyCycle = cycle;
      checkOutput({name, " latency"}, lat, waitOf[d] + 1);
      popCheck(d, name);
    end
    @(negedge clk);
  endtask

  initial begin
    int rc, rc2, cnt, dropAt;
    vecs = '{
      '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0},
      '{1'b0, 32'h0000_0010, 32'h0,         1'b0},
      '{1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0},
      '{1'b1, 32'h0000_0004, 32'h2222_2222, 1'b0},
      '{1'b0, 32'h0000_0006, 32'h0,         1'b1},
      '{1'b1, 32'h0000_0006, 32'h0BAD_BAD0, 1'b1},
      '{1'b0, 32'h0000_0004, 32'h0,         1'b0},
      '{1'b1, 32'h0000_0100, 32'h0BAD_BAD1, 1'b1},
      '{1'b0, 32'h0000_0000, 32'h0,         1'b0},
      '{1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 1'b0},
      '{1'b0, 32'h1000_0020, 32'h0,         1'b1},
      '{1'b0, 32'h0000_0020, 32'h0,         1'b0},
      '{1'b1, 32'h0000_00FC, 32'h1234_5678, 1'b0},
      '{1'b0, 32'h0000_00FC, 32'h0,         1'b0},
      '{1'b1, 32'h0000_0034, 32'h0000_0077, 1'b0}
    };
    modelRd = '{32'h0, 32'h0};
    addr  = '{32'h0, 32'h0};
    wdata = '{32'h0, 32'h0};

    repeat (2) @(negedge clk);
    checkOutput("reset ready", {30'd0, ready}, 32'h0);
    checkOutput("reset err",   {30'd0, err},   32'h0);
    checkOutput("reset rdata", rdata[0], 32'h0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      applyStimulus(0, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].expErr, 0,
                    $sformatf("vec%0d", i), rc);

    // Reset during the wait of a store: nothing commits and no ready ever appears.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hFFFF_0000;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; req[0] = 1'b0;
    cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (ready[0]) cnt++;
    end
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (ready[0]) cnt++;
    end
    checkOutput("midreset ready pulses", cnt, 0);
    checkOutput("midreset rdata", rdata[0], 32'h0);
    modelRd[0] = 32'h0;
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 1'b0, 0, "midreset readback", rc);

    applyStimulus(0, 1'b1, 32'h30, 32'h0000_0055, 1'b0, 1, "captured store", rc);
    applyStimulus(0, 1'b0, 32'h30, 32'h0, 1'b0, 0, "captured readback", rc);
    applyStimulus(0, 1'b0, 32'h34, 32'h0, 1'b0, 0, "neighbour readback", rc);

    // req held through the IDLE cycle after RESP is sampled as one further read.
    pushExpect(0, 1'b0, 32'h10, 32'h0, 1'b0);
    pushExpect(0, 1'b0, 32'h10, 32'h0, 1'b0);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    cnt = 0; dropAt = -1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == dropAt) req[0] = 1'b0;
      if (ready[0]) begin
        cnt++;
        if (cnt == 1) dropAt = i + 2;
        if (sb.size() > 0) popCheck(0, $sformatf("hold read%0d", cnt));
      end
    end
    req[0] = 1'b0;
    checkOutput("hold ready count", cnt, 2);
    sb.delete();

    applyStimulus(1, 1'b1, 32'h0, 32'h11, 1'b0, 0, "w0 store0", rc);
    applyStimulus(1, 1'b1, 32'h4, 32'h22, 1'b0, 0, "w0 store1", rc);
    applyStimulus(1, 1'b0, 32'h0, 32'h0,  1'b0, 0, "w0 read0",  rc);
    applyStimulus(1, 1'b0, 32'h4, 32'h0,  1'b0, 0, "w0 read1",  rc2);
    checkOutput("w0 ready spacing", rc2 - rc, 2);
    applyStimulus(1, 1'b0, 32'h6, 32'h0,  1'b1, 0, "w0 misaligned", rc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
